ram_init: RTL
=============

RAM_INIT -- requirements
Module: ram_init

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RDW_NEW, default 0: read-during-write mode; 0 = old data, 1 = new data.
REQ-004 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port we, input, 1: write request.
REQ-007 Port w_addr, input, ADDR_W: write address.
REQ-008 Port w_data, input, DATA_W: write data.
REQ-009 Port w_be, input, DATA_W/8: byte enables; bit i covers w_data[8i+7:8i].
REQ-010 Port re, input, 1: read request.
REQ-011 Port r_addr, input, ADDR_W: read address.
REQ-012 Port r_data, output, DATA_W: registered read data.
REQ-013 Port r_valid, output, 1: r_data updated this cycle by an accepted read.
REQ-014 Port busy, output, 1: clear sequence in progress; requests ignored.

Function
REQ-015 Two states SHALL exist: CLEAR and RUN.
REQ-016 CLEAR SHALL write all-zero to mem[cnt] each cycle, cnt counting 0 to DEPTH-1.
REQ-017 At the edge that clears word DEPTH-1, the state SHALL go to RUN and cnt SHALL return to 0.
REQ-018 The full clear SHALL take exactly DEPTH cycles after rst_n is first sampled high.
REQ-019 busy SHALL be 1 in CLEAR and while rst_n is low, and 0 in RUN.
REQ-020 In CLEAR, we and re SHALL be ignored, r_valid SHALL stay 0, and r_data SHALL hold.
REQ-021 In RUN, for a write (we=1), each byte i with w_be[i]=1 SHALL update mem[w_addr] at the edge.
REQ-022 Bytes with w_be[i]=0 SHALL keep their value; we=1 with w_be all zero SHALL leave memory unchanged.
REQ-023 A read accepted in RUN (re=1) at edge N SHALL load r_data with mem[r_addr] and set r_valid=1, both visible after edge N: one-cycle latency.
REQ-024 When re=0 in RUN, r_valid SHALL be 0 and r_data SHALL hold its last value.
REQ-025 Read-during-write, we=re=1 and r_addr==w_addr, RDW_NEW=0: r_data SHALL be the pre-write word.
REQ-026 Read-during-write, RDW_NEW=1: r_data SHALL be the merged word (enabled bytes from w_data, other bytes from the old word).
REQ-027 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-028 Addresses SHALL cover exactly DEPTH words; no out-of-range case exists.
REQ-029 mem SHALL be plain storage with no reset network; clearing is done only by the CLEAR sequence.

Reset
REQ-030 rst_n=0 at an edge SHALL set: state=CLEAR, cnt=0, r_data=0, r_valid=0, busy=1.
REQ-031 While rst_n=0, no memory write SHALL occur.
REQ-032 Reset asserted mid-CLEAR or mid-RUN SHALL restart the clear from address 0 after release; RUN writes in flight are discarded.

Verification
REQ-033 Default params: release rst_n, count cycles -> busy high exactly 32 cycles; then reads of all 32 addresses -> 0, each with r_valid one cycle after re.
REQ-034 RUN: we=1, w_addr=3, w_data=0xAABBCCDD, w_be=4'b0101; then read addr 3 -> r_data=0x00BB00DD, r_valid=1 the next cycle.
REQ-035 mem[7]=0x11111111; same-edge write addr 7 data 0x22222222 w_be=4'hF with read addr 7 -> 0x11111111 (RDW_NEW=0); 0x22222222 (RDW_NEW=1).
REQ-036 we=1 and re=1 held while busy=1 -> r_valid stays 0; after clear, the targeted addresses read 0.
REQ-037 Write 0x5 to addr 9, assert rst_n=0 for one cycle, release -> busy high 32 cycles, then addr 9 reads 0, r_data=0 until the first read.
REQ-038 DATA_W=16, ADDR_W=3: clear lasts 8 cycles; w_be=2'b10 with w_data 0xABCD to addr 7 -> reads 0xAB00.

Source files
------------

// File: rtl/ram_init.sv
// Byte-enabled 1R1W synchronous RAM that zero-fills itself after every reset.
// Requests are ignored while the clear sweep is running (busy=1).
module ram_init #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          RDW_NEW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic                r_valid_q, r_valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   merged;

  // Current word at w_addr with the enabled bytes replaced by w_data.
  always_comb begin
    merged = mem_q[w_addr];
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (w_be[i]) merged[8*i +: 8] = w_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_addr  = w_addr;
    mem_wdata = merged;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        mem_we = we;
        if (re) begin
          r_valid_d = 1'b1;
          // Same-address collision returns the merged word only in new-data mode.
          r_data_d  = (RDW_NEW && we && (r_addr == w_addr)) ? merged : mem_q[r_addr];
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      busy_q    <= busy_d;
    end
  end

  // Storage has no reset; it is zeroed only by the clear sweep.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign busy    = busy_q;

endmodule
